// File: rtl/memory_bus_responder_pkg.sv
// rtl/memory_bus_responder_pkg.sv - shared types, constants and fault rule for the memory bus responder
//
// Package mem_bus_pkg
//   DATA_WIDTH    : bus data width
//   resp_state_e  : responder FSM states
//   is_fault()    : misaligned or out-of-range access check

package mem_bus_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } resp_state_e;

    // An access faults when it is not word aligned or its word index lies
    // beyond the end of the RAM.
    function automatic logic is_fault(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/memory_bus_responder_if.sv
// rtl/memory_bus_responder_if.sv - memory bus signal bundle between initiator and responder
//
// Signals
//   strobe      : request valid, held by the initiator until ready
//   address     : byte address, ADDRESS_SIZE bits
//   writeEnable : 1 = write, 0 = read
//   dataWrite   : write data
//   dataRead    : read data, valid while ready=1 and held until the next read completes
//   ready       : one-cycle completion pulse
//   fault       : one-cycle pulse with ready on a faulting access
// Modports: master (initiator), slave (responder)

interface memory_bus_responder_if
    import mem_bus_pkg::*;
#(
    parameter int ADDRESS_SIZE = 15
) ();

    logic                    strobe;
    logic [ADDRESS_SIZE-1:0] address;
    logic                    writeEnable;
    logic [DATA_WIDTH-1:0]   dataWrite;
    logic [DATA_WIDTH-1:0]   dataRead;
    logic                    ready;
    logic                    fault;

    modport master (
        output strobe, address, writeEnable, dataWrite,
        input  dataRead, ready, fault
    );

    modport slave (
        input  strobe, address, writeEnable, dataWrite,
        output dataRead, ready, fault
    );

endinterface

// File: rtl/memory_bus_responder_sp_ram.sv
// rtl/memory_bus_responder_sp_ram.sv - single-port synchronous RAM with one-cycle read latency
//
// Module sp_ram
//   clk   : clock
//   re    : read enable; rdata updates on the next edge only when set
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (returns pre-write contents on a same-cycle write)

module sp_ram #(
    parameter int    DEPTH      = 2048,
    parameter int    DATA_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on the array or output register so the block maps onto BSRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_bus_responder.sv
// rtl/memory_bus_responder.sv - responder end of the memory bus, RAM-backed with wait states
//
// Module memory_bus_responder
//   clock : single clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : memory_bus_responder_if.slave (strobe/address/writeEnable/dataWrite in,
//           dataRead/ready/fault out)
// Latency: strobe seen in IDLE at cycle N -> ready at cycle N+1+WAIT_STATES.

module memory_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int    ADDRESS_SIZE = 15,
    parameter int    DEPTH_WORDS  = 2048,
    parameter int    WAIT_STATES  = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                   clock,
    input  logic                   reset,
    memory_bus_responder_if.slave  bus
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    resp_state_e           state_q, state_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]         addr_idx_q, addr_idx_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] data_read_q, data_read_d;

    logic                  ram_re;
    logic                  ram_we;
    logic [IW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_value;
    logic                  responding;

    sp_ram #(
        .DEPTH      (DEPTH_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clock),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign responding = (state_q == ST_RESPOND);
    // A faulting read returns zero regardless of what the aliased RAM word holds.
    assign rd_value   = fault_q ? '0 : ram_rdata;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_idx_d  = addr_idx_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        data_read_d = data_read_q;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_idx_q;

        case (state_q)
            ST_IDLE: begin
                // The RAM read is launched straight from the bus so its data is
                // ready one cycle later, in time for a zero-wait response.
                ram_addr = bus.address[IW+1:2];
                if (bus.strobe) begin
                    ram_re     = 1'b1;
                    addr_idx_d = bus.address[IW+1:2];
                    we_d       = bus.writeEnable;
                    wdata_d    = bus.dataWrite;
                    fault_d    = is_fault(32'(bus.address), DEPTH_WORDS);
                    wait_cnt_d = CW'(WAIT_STATES);
                    state_d    = (WAIT_STATES == 0) ? ST_RESPOND : ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The counter holds the number of WAIT cycles still to spend,
                // including the current one.
                if (!bus.strobe) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q <= CW'(1)) begin
                    wait_cnt_d = '0;
                    state_d    = ST_RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q - CW'(1);
                end
            end

            ST_RESPOND: begin
                state_d = ST_IDLE;
                ram_we  = we_q && bus.strobe && !fault_q;
                if (!we_q) begin
                    data_read_d = rd_value;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            addr_idx_q  <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            data_read_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_idx_q  <= addr_idx_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            data_read_q <= data_read_d;
        end
    end

    assign bus.ready    = responding;
    assign bus.fault    = responding && fault_q;
    // During the response the fresh read value is forwarded; otherwise the
    // last completed read is held.
    assign bus.dataRead = (responding && !we_q) ? rd_value : data_read_q;

endmodule

// File: tb/tb_memory_bus_responder.sv
// tb/tb_memory_bus_responder.sv - randomized self-checking bench for memory_bus_responder

module tb_memory_bus_responder;

    localparam int AS = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Instance 0: 1 wait state, 1: zero wait states, 2: 3 wait states.
    logic          stb [3];
    logic [AS-1:0] adr [3];
    logic          wen [3];
    logic [31:0]   wdt [3];
    logic          rdy [3];
    logic          flt [3];
    logic [31:0]   rdd [3];

    memory_bus_responder_if #(.ADDRESS_SIZE(AS)) bus0 ();
    memory_bus_responder_if #(.ADDRESS_SIZE(AS)) bus1 ();
    memory_bus_responder_if #(.ADDRESS_SIZE(AS)) bus2 ();

    assign bus0.strobe = stb[0]; assign bus0.address = adr[0]; assign bus0.writeEnable = wen[0]; assign bus0.dataWrite = wdt[0];
    assign bus1.strobe = stb[1]; assign bus1.address = adr[1]; assign bus1.writeEnable = wen[1]; assign bus1.dataWrite = wdt[1];
    assign bus2.strobe = stb[2]; assign bus2.address = adr[2]; assign bus2.writeEnable = wen[2]; assign bus2.dataWrite = wdt[2];
    assign rdy[0] = bus0.ready; assign flt[0] = bus0.fault; assign rdd[0] = bus0.dataRead;
    assign rdy[1] = bus1.ready; assign flt[1] = bus1.fault; assign rdd[1] = bus1.dataRead;
    assign rdy[2] = bus2.ready; assign flt[2] = bus2.fault; assign rdd[2] = bus2.dataRead;

    memory_bus_responder #(.ADDRESS_SIZE(AS), .DEPTH_WORDS(2048), .WAIT_STATES(1), .INIT_FILE(""))
        dut0 (.clock(clk), .reset(rst_n), .bus(bus0));
    memory_bus_responder #(.ADDRESS_SIZE(AS), .DEPTH_WORDS(2048), .WAIT_STATES(0), .INIT_FILE(""))
        dut1 (.clock(clk), .reset(rst_n), .bus(bus1));
    memory_bus_responder #(.ADDRESS_SIZE(AS), .DEPTH_WORDS(2048), .WAIT_STATES(3), .INIT_FILE(""))
        dut2 (.clock(clk), .reset(rst_n), .bus(bus2));

    // Reference model: word store per instance, keyed by instance and word index.
    bit [31:0] model_mem [int];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int mkey(input int d, input logic [AS-1:0] a);
        return d * 65536 + int'(a) / 4;
    endfunction

    function automatic bit mfault(input logic [AS-1:0] a);
        int v;
        v = int'(a);
        return (v % 4 != 0) || (v / 4 >= 2048);
    endfunction

    // Drives one request and waits for ready; lat is the count of sampled
    // cycles from the request cycle to ready (-1 on timeout).
    task automatic txn(input int d, input logic w, input logic [AS-1:0] a, input logic [31:0] data,
                       input bit keep, output int lat, output logic [31:0] rd, output logic f,
                       output int rcyc);
        @(posedge clk); #1;
        stb[d] = 1'b1; wen[d] = w; adr[d] = a; wdt[d] = data;
        lat = -1; rd = '0; f = 1'b0; rcyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                lat = k; rd = rdd[d]; f = flt[d]; rcyc = cyc;
                break;
            end
        end
        if (!keep || lat < 0) begin
            @(posedge clk); #1;
            stb[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++; if (rdy[d] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, rdy[d]); end
            checks++; if (flt[d] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d]: got %b expected 0", d, flt[d]); end
            checks++; if (rdd[d] !== 32'h0) begin errors++; $display("FAIL reset_data[%0d]: got %h expected 0", d, rdd[d]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, rc; logic [31:0] rd; logic f;
        txn(0, 1'b1, 15'h0010, 32'hDEADBEEF, 1'b0, lat, rd, f, rc);
        model_mem[mkey(0, 15'h0010)] = 32'hDEADBEEF;
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL wr_fault: got %b expected 0", f); end
        txn(0, 1'b0, 15'h0010, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL rd_fault: got %b expected 0", f); end
    endtask

    task automatic test_back_to_back();
        int lat, rc, prev; logic [31:0] rd, v; logic f; logic [AS-1:0] a;
        for (int i = 0; i < 4; i++) begin
            a = AS'(4 * i); v = $urandom;
            txn(1, 1'b1, a, v, 1'b0, lat, rd, f, rc);
            model_mem[mkey(1, a)] = v;
        end
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            a = AS'(4 * i);
            txn(1, 1'b0, a, 32'h0, (i != 3), lat, rd, f, rc);
            checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 1", i, lat); end
            checks++; if (rd !== model_mem[mkey(1, a)]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, model_mem[mkey(1, a)]); end
            if (i > 0) begin
                checks++; if (rc - prev !== 2) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 2", i, rc - prev); end
            end
            prev = rc;
        end
    endtask

    task automatic test_fault();
        int lat, rc; logic [31:0] rd; logic f;
        txn(0, 1'b0, 15'h0002, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (lat !== 2 || f !== 1'b1) begin errors++; $display("FAIL misaligned_rd: got lat=%0d fault=%b expected lat=2 fault=1", lat, f); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rd_data: got %h expected 0", rd); end
        txn(0, 1'b1, 15'h0000, 32'h0F0F1234, 1'b0, lat, rd, f, rc);
        model_mem[mkey(0, 15'h0000)] = 32'h0F0F1234;
        txn(0, 1'b0, 15'h2000, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (lat !== 2 || f !== 1'b1) begin errors++; $display("FAIL range_rd: got lat=%0d fault=%b expected lat=2 fault=1", lat, f); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_rd_data: got %h expected 0", rd); end
        txn(0, 1'b1, 15'h2000, 32'hA5A5A5A5, 1'b0, lat, rd, f, rc);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL range_wr_fault: got %b expected 1", f); end
        txn(0, 1'b1, 15'h0012, 32'h0BAD0BAD, 1'b0, lat, rd, f, rc);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL misaligned_wr_fault: got %b expected 1", f); end
        txn(0, 1'b0, 15'h0000, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (rd !== 32'h0F0F1234 || f !== 1'b0) begin errors++; $display("FAIL alias_unchanged: got %h fault=%b expected 0f0f1234 fault=0", rd, f); end
        txn(0, 1'b0, 15'h0010, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_wr_ignored: got %h expected deadbeef", rd); end
    endtask

    task automatic test_abort();
        int lat, rc, seen; logic [31:0] rd; logic f;
        txn(0, 1'b1, 15'h0020, 32'h11112222, 1'b0, lat, rd, f, rc);
        model_mem[mkey(0, 15'h0020)] = 32'h11112222;
        @(posedge clk); #1;
        stb[0] = 1'b1; wen[0] = 1'b1; adr[0] = 15'h0020; wdt[0] = 32'h12345678;
        @(posedge clk); #1;
        stb[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d pulses expected 0", seen); end
        txn(0, 1'b0, 15'h0020, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (rd !== 32'h11112222) begin errors++; $display("FAIL abort_no_write: got %h expected 11112222", rd); end
    endtask

    task automatic test_reset_mid_wait();
        int lat, rc; logic [31:0] rd; logic f;
        txn(2, 1'b1, 15'h0040, 32'h0BADF00D, 1'b0, lat, rd, f, rc);
        model_mem[mkey(2, 15'h0040)] = 32'h0BADF00D;
        txn(2, 1'b0, 15'h0040, 32'h0, 1'b0, lat, rd, f, rc);
        @(posedge clk); #1;
        stb[2] = 1'b1; wen[2] = 1'b1; adr[2] = 15'h0040; wdt[2] = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rdy[2] !== 1'b0 || flt[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_outputs: got ready=%b fault=%b expected 0/0", rdy[2], flt[2]); end
        checks++; if (rdd[2] !== 32'h0) begin errors++; $display("FAIL rst_mid_wait_data: got %h expected 0", rdd[2]); end
        checks++; if (rdd[0] !== 32'h0) begin errors++; $display("FAIL rst_other_data: got %h expected 0", rdd[0]); end
        stb[2] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        txn(2, 1'b0, 15'h0040, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rst_accept_latency: got %0d expected 4", lat); end
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rst_write_dropped: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_long_wait();
        int lat, rc; logic [31:0] rd, v; logic f;
        v = $urandom;
        txn(2, 1'b1, 15'h0044, v, 1'b0, lat, rd, f, rc);
        model_mem[mkey(2, 15'h0044)] = v;
        txn(2, 1'b0, 15'h0044, 32'h0, 1'b0, lat, rd, f, rc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_latency: got %0d expected 4", lat); end
        checks++; if (rd !== v) begin errors++; $display("FAIL ws3_data: got %h expected %h", rd, v); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL ws3_pulse_width[%0d]: got %b expected 0", k, rdy[2]); end
            checks++; if (rdd[2] !== v) begin errors++; $display("FAIL ws3_data_hold[%0d]: got %h expected %h", k, rdd[2], v); end
        end
    endtask

    task automatic test_random();
        int lat, rc, r, key; logic [31:0] rd, v; logic f, w, ef; logic [AS-1:0] a;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 30; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7)      a = AS'(32'h100 + 4 * $urandom_range(0, 15));
                else if (r < 8) a = AS'(32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3));
                else            a = AS'(32'h2000 + 4 * $urandom_range(0, 2047));
                w = 1'($urandom_range(0, 1));
                v = $urandom;
                ef = mfault(a);
                txn(d, w, a, v, 1'b0, lat, rd, f, rc);
                checks++; if (lat !== 1 + ws_of(d) || f !== ef) begin errors++; $display("FAIL rand[%0d.%0d] addr=%h we=%b: got lat=%0d fault=%b expected lat=%0d fault=%b", d, i, a, w, lat, f, 1 + ws_of(d), ef); end
                key = mkey(d, a);
                if (w && !ef) begin
                    model_mem[key] = v;
                end else if (!w && ef) begin
                    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rand_fault_data[%0d.%0d]: got %h expected 0", d, i, rd); end
                end else if (!w && model_mem.exists(key)) begin
                    checks++; if (rd !== model_mem[key]) begin errors++; $display("FAIL rand_data[%0d.%0d] addr=%h: got %h expected %h", d, i, a, rd, model_mem[key]); end
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            stb[d] = 1'b0; adr[d] = '0; wen[d] = 1'b0; wdt[d] = '0;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fault();
        test_abort();
        test_reset_mid_wait();
        test_long_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
